int_resp: RTL and testbench
===========================

# int_resp

CPU-side interrupt responder: the consumer of the interrupt controller's `irq`/`EAddr` pair and the producer of its `iack`. It samples a pending request at an instruction boundary and captures the return PC into `epc`. It redirects fetch to the vector, pulses `iack` back to the controller, and tracks the in-service window until the return instruction, when it redirects fetch back to `epc`. It sits between the interrupt controller and the core's fetch/PC logic.

## Interface
- `ADDR_W`, 32, width of PC, vector and EPC
- `IACK_LEN`, 1, number of cycles `iack` is held high (1..15)

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `irq` in 1: interrupt request from the controller, level
- `EAddr` in ADDR_W: handler vector from the controller, valid while `irq`=1
- `pc_next` in ADDR_W: address of the next sequential instruction (the return address)
- `boundary` in 1: an instruction retires this cycle; safe point to interrupt
- `eret` in 1: the retiring instruction is a return-from-interrupt; qualified by `boundary`
- `ie_set` in 1: software interrupt-enable set
- `ie_clr` in 1: software interrupt-enable clear
- `iack` out 1: acknowledge to the controller
- `redirect` out 1: one-cycle fetch redirect strobe
- `redirect_addr` out ADDR_W: fetch target, valid when `redirect`=1
- `epc` out ADDR_W: saved return address
- `ie` out 1: global interrupt enable
- `in_service` out 1: a handler is executing

## Operation
- States:
  - IDLE: no handler active.
  - TAKE: redirect to the vector.
  - ACK: `iack` hold-extend.
  - SERVICE: handler running.
  - RET: redirect to `epc`.
- IDLE -> TAKE when `irq & ie & boundary`, all in the same cycle.
  - On that edge: `epc` <= `pc_next`, `vec` <= `EAddr`, `ie` <= 0.
- TAKE, one cycle:
  - `redirect`=1, `redirect_addr`=`vec`, `iack`=1.
  - Next state is ACK if IACK_LEN>1, else SERVICE.
- ACK:
  - `iack`=1 until a total of IACK_LEN cycles of `iack` have elapsed, counted from TAKE; then SERVICE.
  - `eret` is ignored in ACK.
- SERVICE:
  - `in_service`=1.
  - `boundary & eret` -> RET.
  - `irq` is ignored: no nesting.
- RET, one cycle:
  - `redirect`=1, `redirect_addr`=`epc`, `ie` <= 1.
  - Next state is IDLE.
- `ie` update priority per cycle: TAKE/RET internal update > `ie_clr` > `ie_set`.
- `eret` outside SERVICE, or without `boundary`: ignored.
- `irq` deasserted before a boundary: nothing happens; no ack.
- `epc` and `vec` hold their values outside the capture edge.

## Timing
- Reset values:
  - state IDLE, `ie`=0, `epc`=0, `vec`=0.
  - `iack`=0, `redirect`=0, `redirect_addr`=0, `in_service`=0.
- Reset is asynchronous and may assert mid-handler. The block returns to IDLE immediately; no RET redirect is issued.
- Outputs are decoded from registered state/counter only, with no combinational path from inputs to outputs.
- Latency:
  - Capture edge (boundary cycle N): `redirect` and `iack` are high in cycle N+1.
  - `in_service` is high from cycle N+1+IACK_LEN.
  - `eret` at cycle M: `redirect` to `epc` in cycle M+1; IDLE and `ie`=1 at M+2.
- Back-to-back: IDLE in cycle M+2 may take a new interrupt if `irq & boundary` hold then. `ie` is already 1 at M+2.
- `ie_set` at the capture edge: the TAKE clear wins, so `ie`=0.
- The `iack` counter is 4 bits. No wrap: it saturates at IACK_LEN.

## Structure
- Shared package `int_pkg`:
  - state enum `int_state_t` {IDLE, TAKE, ACK, SERVICE, RET}.
  - `IACK_CNT_W`=4.
  - default `ADDR_W`.
- No sub-module is needed. The state register, the `epc`/`vec`/`ie` registers and the counter live in one always block plus output decode.

## Test plan
- Reset, then `ie_set`; `irq`=1, `EAddr`=0x0000_0100, `pc_next`=0x0000_2004, `boundary`=1 in cycle 10 -> cycle 11: `redirect`=1, `redirect_addr`=0x100, `iack`=1, `ie`=0; `epc`=0x2004.
- IACK_LEN=3 -> `iack` high for exactly cycles 11-13; `in_service` rises in cycle 14; `eret` held in cycle 12 is ignored.
- In SERVICE, `boundary & eret` in cycle 20 -> cycle 21: `redirect`=1, `redirect_addr`=0x2004; cycle 22: `ie`=1, IDLE; a held `irq` with `boundary` in cycle 22 -> TAKE in cycle 23.
- `ie`=0 with `irq & boundary` -> no `redirect`, no `iack`. Also `irq` high for 5 cycles with `boundary`=0, then dropped -> nothing.
- Simultaneous `ie_set & ie_clr` -> `ie`=0. `rst` low in SERVICE -> all outputs and `epc` zero asynchronously, and the state is IDLE after release.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and constants for the CPU-side interrupt responder.
package int_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 32;
    localparam int unsigned IACK_CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        TAKE,
        ACK,
        SERVICE,
        RET
    } int_state_t;

endpackage

// File: rtl/int_resp.sv
// Interrupt responder: takes a pending irq at an instruction boundary, redirects fetch to the
// vector, acknowledges the controller, and returns to the saved PC on eret.
module int_resp
    import int_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned IACK_LEN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [ADDR_W-1:0] EAddr,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              boundary,
    input  logic              eret,
    input  logic              ie_set,
    input  logic              ie_clr,
    output logic              iack,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] epc,
    output logic              ie,
    output logic              in_service
);

    localparam logic [IACK_CNT_W-1:0] IACK_MAX = IACK_CNT_W'(IACK_LEN);

    int_state_t              state;
    logic [IACK_CNT_W-1:0]   iack_cnt;
    logic [ADDR_W-1:0]       vec;
    logic                    take;

    assign take = (state == IDLE) && irq && ie && boundary;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            iack_cnt <= '0;
            epc      <= '0;
            vec      <= '0;
            ie       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        state    <= TAKE;
                        iack_cnt <= IACK_CNT_W'(1);
                        epc      <= pc_next;
                        vec      <= EAddr;
                    end
                end
                TAKE: begin
                    if (IACK_LEN > 1) begin
                        state    <= ACK;
                        iack_cnt <= iack_cnt + IACK_CNT_W'(1);
                    end else begin
                        state <= SERVICE;
                    end
                end
                // The TAKE cycle already counts as the first iack cycle.
                ACK: begin
                    if (iack_cnt >= IACK_MAX) begin
                        state <= SERVICE;
                    end else begin
                        iack_cnt <= iack_cnt + IACK_CNT_W'(1);
                    end
                end
                SERVICE: begin
                    if (boundary && eret) begin
                        state <= RET;
                    end
                end
                RET:     state <= IDLE;
                default: state <= IDLE;
            endcase

            // Taking or returning from an interrupt overrides software enable writes.
            if (take) begin
                ie <= 1'b0;
            end else if (state == RET) begin
                ie <= 1'b1;
            end else if (ie_clr) begin
                ie <= 1'b0;
            end else if (ie_set) begin
                ie <= 1'b1;
            end
        end
    end

    always_comb begin
        iack          = (state == TAKE) || (state == ACK);
        redirect      = (state == TAKE) || (state == RET);
        in_service    = (state == SERVICE);
        redirect_addr = '0;
        if (state == TAKE) begin
            redirect_addr = vec;
        end else if (state == RET) begin
            redirect_addr = epc;
        end
    end

endmodule

// File: tb/tb_int_resp.sv
// Directed, table-driven bench for int_resp with a 3-cycle iack hold.
module tb_int_resp;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          irq = 1'b0;
    logic [AW-1:0] EAddr = '0;
    logic [AW-1:0] pc_next = '0;
    logic          boundary = 1'b0;
    logic          eret = 1'b0;
    logic          ie_set = 1'b0;
    logic          ie_clr = 1'b0;
    logic          iack;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [AW-1:0] epc;
    logic          ie;
    logic          in_service;

    int checks = 0;
    int errors = 0;

    int_resp #(
        .ADDR_W  (AW),
        .IACK_LEN(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq),
        .EAddr        (EAddr),
        .pc_next      (pc_next),
        .boundary     (boundary),
        .eret         (eret),
        .ie_set       (ie_set),
        .ie_clr       (ie_clr),
        .iack         (iack),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .epc          (epc),
        .ie           (ie),
        .in_service   (in_service)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          irq, bnd, er, st, cl;
        logic [AW-1:0] ea, pc;
        logic          red, ack, ins, ien;
        logic [AW-1:0] addr, epc;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic i, b, r, s, c, input logic [AW-1:0] ea, pc,
                                input logic red, ack, ins, ien, input logic [AW-1:0] ad, ep);
        vec_t v;
        v.irq = i; v.bnd = b; v.er = r; v.st = s; v.cl = c; v.ea = ea; v.pc = pc;
        v.red = red; v.ack = ack; v.ins = ins; v.ien = ien; v.addr = ad; v.epc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic red, ack, ins, ien,
                            input logic [AW-1:0] ad, ep);
        chk({tag, ".redirect"}, AW'(redirect), AW'(red));
        chk({tag, ".iack"}, AW'(iack), AW'(ack));
        chk({tag, ".in_service"}, AW'(in_service), AW'(ins));
        chk({tag, ".ie"}, AW'(ie), AW'(ien));
        chk({tag, ".epc"}, epc, ep);
        if (red) chk({tag, ".redirect_addr"}, redirect_addr, ad);
    endtask

    initial begin
        //                i  b  er s  c  EAddr        pc_next        red ack ins ie  addr         epc
        tbl[0]  = mk(0, 0, 0, 1, 0, 32'h0,       32'h0,       0, 0, 0, 1, 32'h0,    32'h0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 32'h100,     32'h2004,    1, 1, 0, 0, 32'h100,  32'h2004);
        tbl[2]  = mk(1, 0, 1, 0, 0, 32'h100,     32'h2004,    0, 1, 0, 0, 32'h0,    32'h2004);
        tbl[3]  = mk(0, 1, 1, 0, 0, 32'h100,     32'h2004,    0, 1, 0, 0, 32'h0,    32'h2004);
        tbl[4]  = mk(0, 0, 0, 0, 0, 32'h100,     32'h2004,    0, 0, 1, 0, 32'h0,    32'h2004);
        tbl[5]  = mk(1, 1, 0, 0, 0, 32'h999,     32'h9990,    0, 0, 1, 0, 32'h0,    32'h2004);
        tbl[6]  = mk(0, 1, 1, 0, 0, 32'h999,     32'h9990,    1, 0, 0, 0, 32'h2004, 32'h2004);
        tbl[7]  = mk(1, 1, 0, 0, 0, 32'h200,     32'h3008,    0, 0, 0, 1, 32'h0,    32'h2004);
        tbl[8]  = mk(1, 1, 0, 0, 0, 32'h200,     32'h3008,    1, 1, 0, 0, 32'h200,  32'h3008);
        tbl[9]  = mk(0, 0, 0, 0, 0, 32'h200,     32'h3008,    0, 1, 0, 0, 32'h0,    32'h3008);
        tbl[10] = mk(0, 0, 0, 0, 0, 32'h200,     32'h3008,    0, 1, 0, 0, 32'h0,    32'h3008);
        tbl[11] = mk(0, 0, 0, 0, 0, 32'h200,     32'h3008,    0, 0, 1, 0, 32'h0,    32'h3008);
        tbl[12] = mk(0, 0, 1, 0, 0, 32'h200,     32'h3008,    0, 0, 1, 0, 32'h0,    32'h3008);
        tbl[13] = mk(0, 1, 1, 0, 0, 32'h200,     32'h3008,    1, 0, 0, 0, 32'h3008, 32'h3008);
        tbl[14] = mk(0, 0, 0, 0, 0, 32'h200,     32'h3008,    0, 0, 0, 1, 32'h0,    32'h3008);
        tbl[15] = mk(0, 0, 0, 1, 1, 32'h200,     32'h3008,    0, 0, 0, 0, 32'h0,    32'h3008);
        tbl[16] = mk(1, 1, 0, 0, 0, 32'h700,     32'h7000,    0, 0, 0, 0, 32'h0,    32'h3008);
        tbl[17] = mk(1, 0, 0, 1, 0, 32'h700,     32'h7000,    0, 0, 0, 1, 32'h0,    32'h3008);
        for (int i = 18; i < 22; i++)
            tbl[i] = mk(1, 0, 0, 0, 0, 32'h700,  32'h7000,    0, 0, 0, 1, 32'h0,    32'h3008);
        tbl[22] = mk(0, 1, 0, 0, 0, 32'h700,     32'h7000,    0, 0, 0, 1, 32'h0,    32'h3008);
        tbl[23] = mk(1, 1, 0, 1, 0, 32'h400,     32'h5000,    1, 1, 0, 0, 32'h400,  32'h5000);

        step();
        step();
        chk_outs("reset", 0, 0, 0, 0, 32'h0, 32'h0);
        chk("reset.redirect_addr", redirect_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            irq = tbl[i].irq; boundary = tbl[i].bnd; eret = tbl[i].er;
            ie_set = tbl[i].st; ie_clr = tbl[i].cl; EAddr = tbl[i].ea; pc_next = tbl[i].pc;
            step();
            chk_outs($sformatf("row%0d", i), tbl[i].red, tbl[i].ack, tbl[i].ins, tbl[i].ien,
                     tbl[i].addr, tbl[i].epc);
        end

        // Finish the last take into SERVICE, then reset asynchronously mid-handler.
        irq = 0; boundary = 0; eret = 0; ie_set = 0; ie_clr = 0;
        step();
        chk_outs("ack1", 0, 1, 0, 0, 32'h0, 32'h5000);
        step();
        chk_outs("ack2", 0, 1, 0, 0, 32'h0, 32'h5000);
        step();
        chk_outs("svc", 0, 0, 1, 0, 32'h0, 32'h5000);
        #2;
        rst = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 32'h0, 32'h0);
        chk("async_rst.redirect_addr", redirect_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        boundary = 1; eret = 1;
        step();
        chk_outs("post_rst", 0, 0, 0, 0, 32'h0, 32'h0);

        // A fresh take after release proves the state restarted in IDLE.
        boundary = 0; eret = 0; ie_set = 1;
        step();
        ie_set = 0; irq = 1; boundary = 1; EAddr = 32'h80; pc_next = 32'h44;
        step();
        chk_outs("retake", 1, 1, 0, 0, 32'h80, 32'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
